cp_insert_ctrl: RTL

CP_INSERT_CTRL -- requirements
Module: cp_insert_ctrl

---
 rtl/ofdm_pkg.sv | 20 ++
 rtl/sym_ram.sv | 23 ++
 rtl/cp_insert_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/ofdm_pkg.sv
// Shared OFDM definitions: cyclic-prefix ratio codes, reader states and the
// prefix-length decode used by the CP insertion controller.
package ofdm_pkg;

   localparam logic [1:0] CP_SEL_4  = 2'b00;
   localparam logic [1:0] CP_SEL_8  = 2'b01;
   localparam logic [1:0] CP_SEL_16 = 2'b10;
   localparam logic [1:0] CP_SEL_32 = 2'b11;

   typedef enum logic [1:0] {
      RD_IDLE = 2'd0,
      RD_CP   = 2'd1,
      RD_BODY = 2'd2
   } rd_state_t;

   function automatic int unsigned ncp_len(input logic [1:0] sel, input int unsigned nfft);
      return nfft >> (2 + int'(sel));
   endfunction

endpackage

// File: rtl/sym_ram.sv
// Simple dual-port symbol buffer: one write port, one registered read port
// whose output holds while rd_en is low.
module sym_ram #(
   parameter int WIDTH = 32,
   parameter int AW    = 9
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_dat,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_dat
);

   logic [WIDTH-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_dat;
      if (rd_en) rd_dat <= mem[rd_addr];
   end

endmodule

// File: rtl/cp_insert_ctrl.sv
// Cyclic-prefix inserter: ping-pong symbol buffer, reader replays the tail of
// each symbol as its prefix and then streams the full body.
//
// state   | meaning
// RD_IDLE | no full bank to read
// RD_CP   | issuing prefix reads, idx NFFT-NCP..NFFT-1
// RD_BODY | issuing body reads, idx 0..NFFT-1
module cp_insert_ctrl
   import ofdm_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int NFFT  = 256,
   parameter int B     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       cp_sel,
   input  logic [WIDTH-1:0] in_dat,
   input  logic             in_val,
   output logic             in_rdy,
   output logic [WIDTH-1:0] out_dat,
   output logic             out_val,
   input  logic             out_rdy,
   output logic             out_sop,
   output logic             out_eop,
   output logic             busy
);

   localparam logic [B-1:0] LAST = B'(NFFT - 1);

   logic [1:0]       full;
   logic             wb, rb, rb_nxt;
   logic [B-1:0]     widx, ridx, ridx_nxt, rd_idx;
   logic [1:0]       sel_bank [2];
   rd_state_t        state, state_nxt;
   logic             wr_en, advance, rd_issue, clr_full;
   logic             active, cur_cp, sop_i, eop_i;
   logic             pend, pend_sop, pend_eop;
   logic [WIDTH-1:0] ram_q;

   function automatic logic [B-1:0] cp_start(input logic [1:0] sel);
      return B'(NFFT - int'(ncp_len(sel, NFFT)));
   endfunction

   assign in_rdy  = !full[wb];
   assign wr_en   = in_val && in_rdy;
   assign advance = !out_val || out_rdy;
   assign busy    = (|full) || (state != RD_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         wb   <= 1'b0;
         widx <= '0;
      end else if (wr_en) begin
         if (widx == LAST) begin
            wb   <= ~wb;
            widx <= '0;
         end else begin
            widx <= widx + B'(1);
         end
      end
   end

   // Prefix ratio is captured with the first sample so mid-symbol changes are ignored.
   always_ff @(posedge clk) begin
      if (wr_en && widx == '0) sel_bank[wb] <= cp_sel;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         full <= 2'b00;
      end else begin
         if (wr_en && widx == LAST) full[wb] <= 1'b1;
         if (clr_full) full[rb] <= 1'b0;
      end
   end

   // Leaving IDLE issues the first prefix read in the same cycle to save latency.
   always_comb begin
      state_nxt = state;
      rb_nxt    = rb;
      ridx_nxt  = ridx;
      rd_idx    = ridx;
      active    = (state != RD_IDLE);
      cur_cp    = (state == RD_CP);
      rd_issue  = 1'b0;
      sop_i     = 1'b0;
      eop_i     = 1'b0;
      clr_full  = 1'b0;
      if (state == RD_IDLE && full[rb]) begin
         active    = 1'b1;
         cur_cp    = 1'b1;
         rd_idx    = cp_start(sel_bank[rb]);
         state_nxt = RD_CP;
         ridx_nxt  = rd_idx;
      end
      if (active && advance) begin
         rd_issue = 1'b1;
         sop_i    = cur_cp && (rd_idx == cp_start(sel_bank[rb]));
         if (rd_idx != LAST) begin
            ridx_nxt = rd_idx + B'(1);
         end else if (cur_cp) begin
            state_nxt = RD_BODY;
            ridx_nxt  = '0;
         end else begin
            eop_i    = 1'b1;
            clr_full = 1'b1;
            rb_nxt   = ~rb;
            if (full[~rb]) begin
               state_nxt = RD_CP;
               ridx_nxt  = cp_start(sel_bank[~rb]);
            end else begin
               state_nxt = RD_IDLE;
               ridx_nxt  = '0;
            end
         end
      end
   end

   // pend marks valid data sitting in the RAM read register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= RD_IDLE;
         rb       <= 1'b0;
         ridx     <= '0;
         pend     <= 1'b0;
         pend_sop <= 1'b0;
         pend_eop <= 1'b0;
         out_val  <= 1'b0;
         out_sop  <= 1'b0;
         out_eop  <= 1'b0;
         out_dat  <= '0;
      end else begin
         state <= state_nxt;
         rb    <= rb_nxt;
         ridx  <= ridx_nxt;
         if (advance) begin
            pend     <= rd_issue;
            pend_sop <= rd_issue && sop_i;
            pend_eop <= rd_issue && eop_i;
            out_val  <= pend;
            out_sop  <= pend && pend_sop;
            out_eop  <= pend && pend_eop;
            if (pend) out_dat <= ram_q;
         end
      end
   end

   sym_ram #(
      .WIDTH (WIDTH),
      .AW    (B + 1)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr ({wb, widx}),
      .wr_dat  (in_dat),
      .rd_en   (rd_issue),
      .rd_addr ({rb, rd_idx}),
      .rd_dat  (ram_q)
   );

endmodule
